serial2parallel: RTL and testbench

- Receive-side counterpart of the team's 8-bit parallel-to-serial shifter.
- Deserialises an unframed single-wire bit stream into a parallel word, LSB first by default.
- A one-cycle frame-start strobe marks the first bit; no start/stop bits on the line.
- Issues a one-cycle valid pulse with the assembled word. Sits at the receiving end of the serial link, before the parallel consumer.

---
 rtl/serial2parallel_if.sv | 22 ++
 rtl/serial2parallel.sv | 103 ++++++++++
 tb/tb_serial2parallel.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/serial2parallel_if.sv
// Receive-side serial link bundle: frame strobe and bit in, assembled word and status out.
// The slave modport is the deserialiser; the master modport is whoever drives the line.
interface serial2parallel_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  en;
    logic                  data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  busy;
    logic                  frame_err;

    modport master (
        output en, data_in,
        input  data_out, data_valid, busy, frame_err
    );

    modport slave (
        input  en, data_in,
        output data_out, data_valid, busy, frame_err
    );
endinterface

// File: rtl/serial2parallel.sv
// Deserialises an unframed bit stream into DATA_WIDTH-bit words; data_valid pulses DATA_WIDTH cycles after en.
// No backpressure: the consumer must take every word on its data_valid pulse.
module serial2parallel #(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                clk,
    input  logic                nrst,
    serial2parallel_if.slave    bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    typedef logic [CW-1:0] ctr_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1
    } state_t;

    state_t                state_q, state_d;
    ctr_t                  bitctr_q, bitctr_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  busy_q, busy_d;
    logic                  frame_err_q, frame_err_d;
    logic                  word_done;
    logic                  restart;

    // Maps received bit number k onto its position in the output word.
    function automatic ctr_t place(input ctr_t k);
        return LSB_FIRST ? k : (ctr_t'(DATA_WIDTH - 1) - k);
    endfunction

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            bitctr_q     <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitctr_q     <= bitctr_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bitctr_d  = bitctr_q;
        shift_d   = shift_q;
        word_done = 1'b0;
        restart   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.en) begin
                    shift_d[place('0)] = bus.data_in;
                    bitctr_d           = ctr_t'(1);
                    state_d            = S_RECV;
                end
            end
            S_RECV: begin
                // A new strobe wins even over the last bit of the current frame.
                if (bus.en) begin
                    restart            = 1'b1;
                    shift_d[place('0)] = bus.data_in;
                    bitctr_d           = ctr_t'(1);
                end else begin
                    shift_d[place(bitctr_q)] = bus.data_in;
                    if (bitctr_q == ctr_t'(DATA_WIDTH - 1)) begin
                        word_done = 1'b1;
                        bitctr_d  = '0;
                        state_d   = S_IDLE;
                    end else begin
                        bitctr_d = bitctr_q + ctr_t'(1);
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                bitctr_d = '0;
            end
        endcase
    end

    always_comb begin
        data_out_d   = word_done ? shift_d : data_out_q;
        data_valid_d = word_done;
        frame_err_d  = restart;
        busy_d       = (state_d == S_RECV);
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_serial2parallel.sv
// Drives one bit stream into an LSB-first and an MSB-first deserialiser and scoreboards both.
// Expectations come from a frame-as-bit-list model; a negedge monitor compares every cycle.
module tb_serial2parallel;
    localparam int DW = 8;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    serial2parallel_if #(.DATA_WIDTH(DW)) if_l ();
    serial2parallel_if #(.DATA_WIDTH(DW)) if_m ();

    serial2parallel #(.DATA_WIDTH(DW), .LSB_FIRST(1'b1)) dut_l (
        .clk  (clk),
        .nrst (nrst),
        .bus  (if_l.slave)
    );

    serial2parallel #(.DATA_WIDTH(DW), .LSB_FIRST(1'b0)) dut_m (
        .clk  (clk),
        .nrst (nrst),
        .bus  (if_m.slave)
    );

    typedef struct {
        int          due;
        logic        dv;
        logic        busy;
        logic        fe;
        logic [DW-1:0] wl;
        logic [DW-1:0] wm;
    } exp_t;

    exp_t          sb[$];
    logic          frame[$];
    logic [DW-1:0] last_l = '0;
    logic [DW-1:0] last_m = '0;
    int            cyc    = 0;
    int            total  = 0;
    int            bad    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        if_l.en = 1'b0; if_l.data_in = 1'b0;
        if_m.en = 1'b0; if_m.data_in = 1'b0;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Monitor: compare every expectation whose due cycle has arrived.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("data_valid_lsb", DW'(if_l.data_valid), DW'(e.dv));
            check("data_valid_msb", DW'(if_m.data_valid), DW'(e.dv));
            check("data_out_lsb",   if_l.data_out,        e.wl);
            check("data_out_msb",   if_m.data_out,        e.wm);
            check("busy_lsb",       DW'(if_l.busy),       DW'(e.busy));
            check("busy_msb",       DW'(if_m.busy),       DW'(e.busy));
            check("frame_err_lsb",  DW'(if_l.frame_err),  DW'(e.fe));
            check("frame_err_msb",  DW'(if_m.frame_err),  DW'(e.fe));
        end
    end

    // One cycle of stimulus; the model treats a frame as the list of bits received so far.
    task automatic drive(input logic rn, input logic e, input logic d);
        exp_t          x;
        logic [DW-1:0] wl;
        logic [DW-1:0] wm;
        @(posedge clk);
        #1;
        nrst = rn;
        if_l.en = e; if_l.data_in = d;
        if_m.en = e; if_m.data_in = d;
        x.due = cyc + 1;
        x.dv  = 1'b0;
        x.fe  = 1'b0;
        if (!rn) begin
            frame.delete();
            last_l = '0;
            last_m = '0;
        end else if (e) begin
            x.fe = (frame.size() > 0);
            frame.delete();
            frame.push_back(d);
        end else if (frame.size() > 0) begin
            frame.push_back(d);
            if (frame.size() == DW) begin
                wl = '0;
                wm = '0;
                for (int k = 0; k < DW; k++) begin
                    wl[k]        = frame[k];
                    wm[DW-1-k]   = frame[k];
                end
                last_l = wl;
                last_m = wm;
                x.dv   = 1'b1;
                frame.delete();
            end
        end
        x.busy = (frame.size() > 0);
        x.wl   = last_l;
        x.wm   = last_m;
        sb.push_back(x);
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        for (int k = 0; k < DW; k++) drive(1'b1, k == 0, w[k]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 1'($urandom));
    endtask

    initial begin
        logic [DW-1:0] lb[4];
        logic [DW-1:0] w;
        lb = '{8'h3C, 8'h00, 8'hFF, 8'h81};

        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, 1'(k % 2));

        send_word(8'hA5);
        idle(3);
        send_word(8'h01);
        idle(2);

        for (int i = 0; i < 4; i++) begin
            send_word(lb[i]);
            idle(1);
        end

        send_word(8'h12);
        send_word(8'hEF);
        idle(2);

        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        send_word(8'h5A);
        idle(2);

        // Restart landing on the last-bit cycle of a frame.
        w = 8'h33;
        for (int k = 0; k < DW - 1; k++) drive(1'b1, k == 0, w[k]);
        send_word(8'h44);
        idle(2);

        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        send_word(8'hC3);
        idle(2);

        for (int k = 0; k < 600; k++)
            drive(1'($urandom_range(0, 199) != 0), $urandom_range(0, 5) == 0, 1'($urandom));

        idle(3);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
